requant_pipe: RTL and testbench

- Multi-lane, pipelined successor to the combinational 32→16 quantizer.
- Takes LANES packed signed MAC accumulators and applies a runtime arithmetic right shift with selectable rounding. Saturates each lane correctly to OUT_W bits and emits the result over valid/ready handshakes with full backpressure.
- Sits between the MAC array and the activation/writeback stage. Keeps a sticky per-lane saturation flag and a saturating event counter for debug.

---
 rtl/requant_pipe.sv | 138 +++++++++++++
 tb/tb_requant_pipe.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_pipe.sv
// Two-stage multi-lane requantizer: round + arithmetic shift, then saturate to OUT_W,
// with valid/ready backpressure and per-lane saturation statistics.
module requant_pipe #(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 16,
    parameter int LANES   = 4,
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*IN_W-1:0]    in_data,
    input  logic [SHIFT_W-1:0]       shift,
    input  logic                     rnd_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   out_data,
    output logic [LANES-1:0]         out_sat,
    output logic [LANES-1:0]         sat_sticky,
    output logic [CNT_W-1:0]         sat_count,
    input  logic                     sat_clear
);

    localparam int EXT_W = IN_W + 1;
    localparam int PC_W  = $clog2(LANES + 1);

    logic                     v1;
    logic                     v2;
    logic                     s1_load;
    logic                     s2_load;
    logic                     s2_enter;
    logic [SHIFT_W-1:0]       shift_eff;
    logic signed [EXT_W-1:0]  acc [LANES];
    logic [EXT_W-1:0]         s1_next [LANES];
    logic [EXT_W-1:0]         s1_q [LANES];
    logic [OUT_W-1:0]         sat_val [LANES];
    logic [LANES-1:0]         sat_flag;
    logic [PC_W-1:0]          sat_pop;
    logic [CNT_W+PC_W-1:0]    cnt_sum;
    logic [CNT_W-1:0]         cnt_next;

    assign s2_load   = !v2 || out_ready;
    assign s1_load   = !v1 || s2_load;
    assign s2_enter  = s2_load && v1;
    assign in_ready  = s1_load;
    assign out_valid = v2;

    always_comb begin
        shift_eff = shift;
        if (int'(shift) >= IN_W) begin
            shift_eff = SHIFT_W'(IN_W - 1);
        end
    end

    // One extra bit of headroom keeps the rounding increment from wrapping a large positive input.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            acc[l] = {in_data[l*IN_W + IN_W - 1], in_data[l*IN_W +: IN_W]};
            if (rnd_mode && (shift_eff != '0)) begin
                acc[l] = acc[l] + (EXT_W'(1) << (shift_eff - 1'b1));
            end
            s1_next[l] = acc[l] >>> shift_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
        end else if (s1_load) begin
            v1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_load && in_valid) begin
            for (int l = 0; l < LANES; l++) begin
                s1_q[l] <= s1_next[l];
            end
        end
    end

    // A lane fits when every bit above the OUT_W sign position matches the sign.
    always_comb begin
        sat_pop = '0;
        for (int l = 0; l < LANES; l++) begin
            if (s1_q[l][EXT_W-1:OUT_W-1] == {(EXT_W-OUT_W+1){s1_q[l][EXT_W-1]}}) begin
                sat_flag[l] = 1'b0;
                sat_val[l]  = s1_q[l][OUT_W-1:0];
            end else begin
                sat_flag[l] = 1'b1;
                sat_val[l]  = s1_q[l][EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                               : {1'b0, {(OUT_W-1){1'b1}}};
            end
            sat_pop = sat_pop + PC_W'(sat_flag[l]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2       <= 1'b0;
            out_data <= '0;
            out_sat  <= '0;
        end else if (s2_load) begin
            v2 <= v1;
            if (v1) begin
                for (int l = 0; l < LANES; l++) begin
                    out_data[l*OUT_W +: OUT_W] <= sat_val[l];
                end
                out_sat <= sat_flag;
            end
        end
    end

    always_comb begin
        cnt_sum  = {{PC_W{1'b0}}, sat_count} + (CNT_W+PC_W)'(sat_pop);
        cnt_next = cnt_sum[CNT_W-1:0];
        if (cnt_sum[CNT_W+PC_W-1:CNT_W] != '0) begin
            cnt_next = '1;
        end
    end

    // Clear wins over a saturating beat landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_sticky <= '0;
            sat_count  <= '0;
        end else if (sat_clear) begin
            sat_sticky <= '0;
            sat_count  <= '0;
        end else if (s2_enter) begin
            sat_sticky <= sat_sticky | sat_flag;
            sat_count  <= cnt_next;
        end
    end

endmodule

// File: tb/tb_requant_pipe.sv
// Self-checking bench for requant_pipe: directed vectors, backpressure, reset/clear,
// and randomized traffic scored against a plain-arithmetic reference model.
module tb_requant_pipe;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  sat;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [4:0]   shift;
    logic         rnd_mode;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic [3:0]   out_sat;
    logic [3:0]   sat_sticky;
    logic [15:0]  sat_count;
    logic         sat_clear;

    logic         in_valid2;
    logic         in_ready2;
    logic [47:0]  in_data2;
    logic [4:0]   shift2;
    logic         rnd_mode2;
    logic         out_valid2;
    logic         out_ready2;
    logic [23:0]  out_data2;
    logic [1:0]   out_sat2;
    logic [1:0]   sat_sticky2;
    logic [2:0]   sat_count2;
    logic         sat_clear2;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_out    = 0;
    int    m_cnt    = 0;
    logic [3:0] m_sticky = '0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    requant_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .shift(shift), .rnd_mode(rnd_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .sat_sticky(sat_sticky), .sat_count(sat_count),
        .sat_clear(sat_clear)
    );

    requant_pipe #(.IN_W(24), .OUT_W(12), .LANES(2), .SHIFT_W(5), .CNT_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .shift(shift2), .rnd_mode(rnd_mode2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_sat(out_sat2), .sat_sticky(sat_sticky2), .sat_count(sat_count2),
        .sat_clear(sat_clear2)
    );

    function automatic longint quantModel(input longint x, input int sh, input bit rnd,
                                          input int in_w, input int out_w, output bit sat);
        longint v;
        longint hi;
        longint lo;
        int     s;
        s  = (sh >= in_w) ? in_w - 1 : sh;
        v  = x;
        if (rnd && s > 0) v = v + (longint'(1) << (s - 1));
        v  = v >>> s;
        hi = (longint'(1) << (out_w - 1)) - 1;
        lo = -(longint'(1) << (out_w - 1));
        sat = (v > hi) || (v < lo);
        if (v > hi) v = hi;
        else if (v < lo) v = lo;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Scoreboard: capture accepted beats, compare consumed beats, and confirm stalled outputs hold.
    always @(negedge clk) begin : monitor
        beat_t       b;
        bit          s;
        longint      v;
        logic        prev_stall;
        logic [63:0] held_data;
        logic [3:0]  held_sat;
        if (!rst_n) begin
            exp_q.delete();
            m_cnt      = 0;
            m_sticky   = '0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_data", out_data, held_data);
                checkOutput("stall_sat", out_sat, held_sat);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_beat", out_valid, 0);
                end else begin
                    b = exp_q.pop_front();
                    checkOutput("lane_data", out_data, b.data);
                    checkOutput("lane_sat", out_sat, b.sat);
                    n_out++;
                end
            end
            prev_stall = out_valid && !out_ready;
            held_data  = out_data;
            held_sat   = out_sat;
            if (in_valid && in_ready) begin
                for (int l = 0; l < 4; l++) begin
                    v = quantModel(longint'($signed(in_data[l*32 +: 32])), int'(shift), rnd_mode, 32, 16, s);
                    b.data[l*16 +: 16] = v[15:0];
                    b.sat[l] = s;
                    if (s && m_cnt < 65535) m_cnt++;
                end
                m_sticky = m_sticky | b.sat;
                exp_q.push_back(b);
            end
        end
    end

    function automatic logic [31:0] randAcc();
        case ($urandom_range(0, 5))
            0, 1: return $urandom;
            2, 3: return 32'($urandom_range(0, 32'h0020_0000)) - 32'h0010_0000;
            4:    return 32'h7FFF_FFFF;
            default: return 32'h8000_0000;
        endcase
    endfunction

    // Call at posedge+1; returns at posedge+1 after the beat has been accepted.
    task automatic applyStimulus(input logic [127:0] d, input logic [4:0] sh, input logic r);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        shift    = sh;
        rnd_mode = r;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) checkOutput("accept_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic directedBeat(input string name, input logic [127:0] d, input logic [4:0] sh,
                                input logic r, input logic [63:0] exp_data, input logic [3:0] exp_sat);
        @(posedge clk); #1;
        applyStimulus(d, sh, r);
        @(negedge clk);
        checkOutput({name, "_latency1"}, out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({name, "_latency2"}, out_valid, 1);
        checkOutput({name, "_data"}, out_data, exp_data);
        checkOutput({name, "_sat"}, out_sat, exp_sat);
    endtask

    task automatic drain();
        int waited = 0;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && waited < 30) begin
            @(posedge clk); #1;
            waited++;
        end
        @(negedge clk);
        checkOutput("drain_empty", exp_q.size(), 0);
        checkOutput("drain_count", sat_count, m_cnt);
        checkOutput("drain_sticky", sat_sticky, m_sticky);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        bit     s;
        int     k;
        int     out0;
        longint v;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; shift = '0; rnd_mode = 1'b0;
        out_ready = 1'b1; sat_clear = 1'b0;
        in_valid2 = 1'b0; in_data2 = '0; shift2 = '0; rnd_mode2 = 1'b0;
        out_ready2 = 1'b1; sat_clear2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_count", sat_count, 0);
        checkOutput("reset_sticky", sat_sticky, 0);

        v = quantModel(64'h1280, 8, 0, 32, 16, s);
        checkOutput("model_trunc", v, 64'h12);
        v = quantModel(-384, 8, 1, 32, 16, s);
        checkOutput("model_round_neg", v, -64'sd1);
        v = quantModel(64'h7FFF_FFFF, 1, 1, 32, 16, s);
        checkOutput("model_round_ovf", {v[62:0], s}, {63'h7FFF, 1'b1});
        v = quantModel(64'h40_0000, 31, 1, 24, 12, s);
        checkOutput("model_clamp", v, 64'h1);

        directedBeat("trunc", {32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FE80, 32'h0000_1280}, 5'd8, 1'b0,
                     {16'h8000, 16'h7FFF, 16'hFFFE, 16'h0012}, 4'b1100);
        checkOutput("trunc_count", sat_count, 2);
        checkOutput("trunc_sticky", sat_sticky, 4'b1100);
        directedBeat("round", {32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FE80, 32'h0000_1280}, 5'd8, 1'b1,
                     {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0013}, 4'b1100);
        directedBeat("shift0", {32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FE80, 32'h0000_1280}, 5'd0, 1'b1,
                     {16'h8000, 16'h7FFF, 16'hFE80, 16'h1280}, 4'b1100);
        directedBeat("rnd_ovf", {32'h0000_0000, 32'hFFFF_FFFD, 32'h0000_0003, 32'h7FFF_FFFF}, 5'd1, 1'b1,
                     {16'h0000, 16'hFFFF, 16'h0002, 16'h7FFF}, 4'b0001);
        directedBeat("shift31", {32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h4000_0000}, 5'd31, 1'b1,
                     {16'h0001, 16'hFFFF, 16'h0000, 16'h0001}, 4'b0000);
        checkOutput("directed_count", sat_count, 7);
        checkOutput("directed_sticky", sat_sticky, 4'b1101);

        @(posedge clk); #1;
        in_valid2 = 1'b1; in_data2 = {24'h7F_FFFF, 24'h40_0000}; shift2 = 5'h1F; rnd_mode2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("clamp_valid", out_valid2, 1);
        checkOutput("clamp_data", out_data2, 24'h001_001);
        checkOutput("clamp_sat", out_sat2, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid2 = 1'b1; in_data2 = {24'h7F_FFFF, 24'h7F_FFFF}; shift2 = 5'd0; rnd_mode2 = 1'b0;
        end
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("small_cnt_data", out_data2, 24'h7FF_7FF);
        checkOutput("small_cnt_6", sat_count2, 6);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            in_valid2 = 1'b1;
        end
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("small_cnt_clamp", sat_count2, 7);
        checkOutput("small_sticky", sat_sticky2, 2'b11);

        @(posedge clk); #1;
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = {randAcc(), randAcc(), randAcc(), randAcc()};
            shift    = 5'($urandom_range(0, 31));
            rnd_mode = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) k++;
            @(posedge clk); #1;
        end
        checkOutput("bp_accepted", k, 2);
        @(negedge clk);
        checkOutput("bp_in_ready", in_ready, 0);
        @(posedge clk); #1;
        out0 = n_out;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (k < 4) begin
                in_valid = 1'b1;
                in_data  = {randAcc(), randAcc(), randAcc(), randAcc()};
                shift    = 5'($urandom_range(0, 31));
                rnd_mode = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checkOutput("bp_all_sent", k, 4);
        checkOutput("bp_one_per_cycle", n_out - out0, 4);
        drain();

        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            for (int l = 0; l < 4; l++) in_data[l*32 +: 32] = randAcc();
            shift    = 5'($urandom_range(0, 31));
            rnd_mode = 1'($urandom_range(0, 1));
        end
        drain();

        @(posedge clk); #1;
        applyStimulus({4{32'h7FFF_FFFF}}, 5'd8, 1'b0);
        sat_clear = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        m_cnt     = 0;
        m_sticky  = '0;
        @(negedge clk);
        checkOutput("clear_count", sat_count, 0);
        checkOutput("clear_sticky", sat_sticky, 0);
        drain();

        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus({4{32'h7FFF_FFFF}}, 5'd4, 1'b0);
        applyStimulus({4{32'h8000_0000}}, 5'd4, 1'b1);
        @(negedge clk);
        checkOutput("full_out_valid", out_valid, 1);
        checkOutput("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_full_out_valid", out_valid, 0);
        checkOutput("rst_full_count", sat_count, 0);
        checkOutput("rst_full_in_ready", in_ready, 1);
        checkOutput("rst_full_sticky", sat_sticky, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
